// File: rtl/sd_pkg.sv
// Shared response codes, FSM state encoding, frame lengths and a CRC7 step for the SD command PHY.
package sd_pkg;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_48   = 2'd1;
  localparam logic [1:0] RESP_136  = 2'd2;

  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int FRAME_LEN_48  = 48;
  localparam int FRAME_LEN_136 = 136;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX,
    ST_TURN,
    ST_WAIT,
    ST_RX,
    ST_GAP
  } state_e;

  // One serial step of x^7+x^3+1, message bits fed MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator (x^7+x^3+1), one bit per enabled cycle, MSB first.
// Latency: crc_out includes a bit the cycle after its en.
// Backpressure: none; clr has priority over en.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       clr,
  input  logic       bit_in,
  output logic [6:0] crc_out
);

  logic [6:0] crc_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      crc_q <= '0;
    end else if (clr) begin
      crc_q <= '0;
    end else if (en) begin
      crc_q <= crc7_step(crc_q, bit_in);
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/sd_cmd_phy.sv
// SD CMD-line PHY: serialises one 48-bit command with CRC7, then captures the R1/R3/R6/R7/R2 response.
// Latency: first bit on the first sd_clk_en after accept; resp_valid on the last TX (type 0) or RX strobe.
// Backpressure: cmd_ready only in IDLE. Macro SD_RESP_CRC_CHK_EN enables the receive CRC check.
module sd_cmd_phy
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64,
  parameter int NCC_GAP = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         sd_clk_en,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         resp_valid,
  output logic [127:0] resp_data,
  output logic         resp_crc_err,
  output logic         resp_timeout,
  output logic         resp_end_err,
  output logic         sd_cmd_o,
  output logic         sd_cmd_oe,
  input  logic         sd_cmd_i
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] TX_LAST     = CNT_W'(FRAME_LEN_48 - 1);
  localparam logic [CNT_W-1:0] TX_CRC_AT   = CNT_W'(FRAME_LEN_48 - 8);
  localparam logic [CNT_W-1:0] RX48_LAST   = CNT_W'(FRAME_LEN_48 - 2);
  localparam logic [CNT_W-1:0] RX136_LAST  = CNT_W'(FRAME_LEN_136 - 2);
  localparam logic [CNT_W-1:0] TURN_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] NCR_LAST    = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(NCC_GAP - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         type_q;
  logic [47:0]        tx_sh_q;
  logic [126:0]       rx_sh_q;
  logic [127:0]       rx_next;
  logic               drv_o_q, drv_oe_q;
  logic               resp_valid_q, crc_err_q, timeout_q, end_err_q;
  logic [127:0]       resp_data_q;

  logic               accept, r2, tx_done, rx_done, rx_start, ncr_expire;
  logic               tx_crc_en, rx_crc_bad;
  logic [6:0]         tx_crc;

  assign accept     = (state_q == ST_IDLE) && cmd_valid;
  assign r2         = (type_q == RESP_136);
  assign rx_next    = {rx_sh_q, sd_cmd_i};
  assign tx_done    = sd_clk_en && (state_q == ST_TX) && (cnt_q == TX_LAST);
  assign rx_done    = sd_clk_en && (state_q == ST_RX) && (cnt_q == (r2 ? RX136_LAST : RX48_LAST));
  assign rx_start   = sd_clk_en && (state_q == ST_WAIT) && !sd_cmd_i;
  assign ncr_expire = sd_clk_en && (state_q == ST_WAIT) && sd_cmd_i && (cnt_q == NCR_LAST);
  assign tx_crc_en  = sd_clk_en && (state_q == ST_TX) && (cnt_q < TX_CRC_AT);

  sd_crc7 u_tx_crc (
    .clk     (clk),
    .resetn  (resetn),
    .en      (tx_crc_en),
    .clr     (accept),
    .bit_in  (tx_sh_q[47]),
    .crc_out (tx_crc)
  );

`ifdef SD_RESP_CRC_CHK_EN
  logic       rx_crc_en;
  logic [6:0] rx_crc;

  // RX count k holds frame bit 46-k (48-bit) or 134-k (R2); only the CRC-covered span is fed.
  assign rx_crc_en = sd_clk_en && (state_q == ST_RX) &&
                     (r2 ? ((cnt_q >= CNT_W'(7)) && (cnt_q <= CNT_W'(126))) : (cnt_q <= CNT_W'(38)));

  sd_crc7 u_rx_crc (
    .clk     (clk),
    .resetn  (resetn),
    .en      (rx_crc_en),
    .clr     (rx_start),
    .bit_in  (sd_cmd_i),
    .crc_out (rx_crc)
  );

  // R3 reports index 6'h3F with a fixed 7'h7F CRC field, so it is exempt.
  assign rx_crc_bad = (rx_crc != rx_next[7:1]) && (r2 || (rx_next[45:40] != 6'h3F));
`else
  assign rx_crc_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_TX;
      ST_TX:   if (tx_done) state_d = (type_q == RESP_NONE) ? ST_GAP : ST_TURN;
      ST_TURN: if (sd_clk_en && (cnt_q == TURN_LAST)) state_d = ST_WAIT;
      ST_WAIT: begin
        if (rx_start)        state_d = ST_RX;
        else if (ncr_expire) state_d = ST_GAP;
      end
      ST_RX:   if (rx_done) state_d = ST_GAP;
      ST_GAP:  if (sd_clk_en && (cnt_q == GAP_LAST)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q    <= '0;
      type_q   <= RESP_NONE;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      drv_o_q  <= 1'b1;
      drv_oe_q <= 1'b0;
    end else begin
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (sd_clk_en && (state_q != ST_IDLE)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (accept) begin
        type_q  <= (resp_type == 2'd3) ? RESP_48 : resp_type;
        tx_sh_q <= {2'b01, cmd_index, cmd_arg, 8'h00};
      end else if (sd_clk_en && (state_q == ST_TX)) begin
        // After the 40 payload bits the register is reloaded with CRC[5:0] and the end bit.
        if (cnt_q == TX_CRC_AT) tx_sh_q <= {tx_crc[5:0], 1'b1, 41'd0};
        else                    tx_sh_q <= {tx_sh_q[46:0], 1'b0};
      end

      if (sd_clk_en) begin
        if (state_q == ST_TX) begin
          drv_oe_q <= 1'b1;
          drv_o_q  <= (cnt_q == TX_CRC_AT) ? tx_crc[6] : tx_sh_q[47];
        end else begin
          drv_oe_q <= (state_d == ST_GAP);
          drv_o_q  <= 1'b1;
        end
      end

      if (rx_start) begin
        rx_sh_q <= '0;
      end else if (sd_clk_en && (state_q == ST_RX)) begin
        rx_sh_q <= rx_next[126:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      crc_err_q    <= 1'b0;
      timeout_q    <= 1'b0;
      end_err_q    <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (tx_done && (type_q == RESP_NONE)) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= '0;
        crc_err_q    <= 1'b0;
        timeout_q    <= 1'b0;
        end_err_q    <= 1'b0;
      end else if (ncr_expire) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= '0;
        crc_err_q    <= 1'b0;
        timeout_q    <= 1'b1;
        end_err_q    <= 1'b0;
      end else if (rx_done) begin
        resp_valid_q <= 1'b1;
        resp_data_q  <= r2 ? rx_next : {90'd0, rx_next[45:8]};
        crc_err_q    <= rx_crc_bad;
        timeout_q    <= 1'b0;
        end_err_q    <= !sd_cmd_i;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_crc_err = crc_err_q;
  assign resp_timeout = timeout_q;
  assign resp_end_err = end_err_q;
  assign sd_cmd_o     = drv_o_q;
  assign sd_cmd_oe    = drv_oe_q;

endmodule
